mem3_result_drainer: RTL and testbench

- Read-side counterpart of mem_writer. It drains dot-product results from mem3 and presents them on a valid/ready output stream.
- Drives mem3's read port (read_en, read_address) and consumes mem3 data_out, which has one-cycle registered read latency.
- Started by the host after processing_done. It emits a contiguous run of result words starting at a given address, wrapping at MEM_SIZE.

---
 rtl/mem3_result_drainer.sv | 148 ++++++++++++++
 tb/tb_mem3_result_drainer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem3_result_drainer.sv
// Drains a contiguous, wrapping run of result words from mem3 and presents
// them on a valid/ready stream. Each word is read, captured, then held until it is accepted.
module mem3_result_drainer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_SIZE   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_drain,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH:0]   drain_count,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      MEM_SIZE_C = CNT_W'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic                  read_en_q, read_en_d;
  logic [ADDR_WIDTH-1:0] read_address_q, read_address_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_wrap;

  assign addr_wrap = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

  // Outputs are computed for the state being entered so every port comes
  // straight from a flop and read_en is high exactly during ISSUE.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    read_en_d      = 1'b0;
    read_address_d = read_address_q;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_last_d       = m_last_q;
    done_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_drain) begin
          if (drain_count != '0) begin
            addr_d         = start_address;
            remaining_d    = (drain_count > MEM_SIZE_C) ? MEM_SIZE_C : drain_count;
            read_en_d      = 1'b1;
            read_address_d = start_address;
            state_d        = ST_ISSUE;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        m_data_d  = data_in;
        m_valid_d = 1'b1;
        m_last_d  = (remaining_q == CNT_W'(1));
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (m_ready) begin
          m_valid_d   = 1'b0;
          m_last_d    = 1'b0;
          remaining_d = remaining_q - 1'b1;
          addr_d      = addr_wrap;
          if (remaining_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            read_en_d      = 1'b1;
            read_address_d = addr_wrap;
            state_d        = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      read_en_q      <= 1'b0;
      read_address_q <= '0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      m_last_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      read_en_q      <= read_en_d;
      read_address_q <= read_address_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign read_en      = read_en_q;
  assign read_address = read_address_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mem3_result_drainer.sv
// Directed bench for mem3_result_drainer: a behavioural mem3 with one-cycle
// read latency is loaded with 0x100+k and drains are checked word by word.
module tb_mem3_result_drainer;

  logic        clk;
  logic        rst_n;
  logic        start_drain;
  logic [4:0]  start_address;
  logic [5:0]  drain_count;
  logic        read_en;
  logic [4:0]  read_address;
  logic [31:0] data_in;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:31];
  logic [31:0] got_q [$];
  int n_cmp;
  int n_err;

  mem3_result_drainer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .MEM_SIZE  (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_drain  (start_drain),
    .start_address(start_address),
    .drain_count  (drain_count),
    .read_en      (read_en),
    .read_address (read_address),
    .data_in      (data_in),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_en) data_in <= mem[read_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One drain: words expected at 0x100 + ((sa + i) mod 32); inject_cyc >= 0
  // pulses a conflicting start_drain mid-drain.
  task automatic run_drain(input string name, input logic [4:0] sa, input logic [5:0] cnt,
                           input int n_exp, input int stall_cycles, input int inject_cyc);
    int hs;
    int reads;
    int done_seen;
    int last_hs_cyc;
    int first_valid_cyc;
    int stall_left;
    bit stalling;
    bit finished;
    logic [31:0] expd;
    logic [4:0]  exp_addr;

    got_q.delete();
    hs = 0; reads = 0; done_seen = 0; last_hs_cyc = -1; first_valid_cyc = -1;
    stall_left = stall_cycles; stalling = 1'b0; finished = 1'b0;
    start_address = sa;
    drain_count   = cnt;
    start_drain   = 1'b1;
    m_ready       = (stall_cycles == 0);
    @(posedge clk); #1;
    start_drain = 1'b0;

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (inject_cyc == cyc) begin
        start_address = sa + 5'd7;
        drain_count   = 6'd1;
        start_drain   = 1'b1;
      end else begin
        start_drain = 1'b0;
      end
      if (read_en) begin
        exp_addr = 5'((int'(sa) + reads) % 32);
        check({name, "_rd_addr"}, 32'(read_address), 32'(exp_addr));
        reads++;
      end
      if (m_valid && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        check({name, "_first_valid_cyc"}, 32'(cyc), 32'd2);
      end
      expd = 32'h100 + 32'((int'(sa) + hs) % 32);
      if (stall_left > 0 && (m_valid || stalling)) begin
        check({name, "_stall_valid"}, 32'(m_valid), 32'd1);
        check({name, "_stall_data"}, m_data, expd);
        m_ready = 1'b0;
        stalling = 1'b1;
        stall_left--;
      end else begin
        m_ready = 1'b1;
        stalling = 1'b0;
      end
      if (m_valid && m_ready) begin
        check({name, "_data"}, m_data, expd);
        check({name, "_last"}, 32'(m_last), 32'(hs == n_exp - 1));
        if (stall_cycles == 0 && last_hs_cyc >= 0)
          check({name, "_gap"}, 32'(cyc - last_hs_cyc), 32'd3);
        $display("%s: handshake %0d data 0x%0h last %0d at cycle %0d", name, hs, m_data, m_last, cyc);
        got_q.push_back(m_data);
        hs++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_seen++;
        check({name, "_done_cyc"}, 32'(cyc), 32'(last_hs_cyc + 1));
        finished = 1'b1;
      end
      @(posedge clk); #1;
    end
    start_drain = 1'b0;
    if (!finished) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_handshakes"}, 32'(hs), 32'(n_exp));
    check({name, "_reads"}, 32'(reads), 32'(n_exp));
    check({name, "_done_count"}, 32'(done_seen), 32'd1);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_done_after"}, 32'(done), 32'd0);
    check({name, "_valid_after"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    bit seen;
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < 32; k++) mem[k] = 32'h100 + 32'(k);
    rst_n = 1'b0; start_drain = 1'b0; start_address = '0; drain_count = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_en", 32'(read_en), 32'd0);
    check("rst_read_addr", 32'(read_address), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_drain("basic", 5'd0, 6'd4, 4, 0, -1);
    check("basic_w0", got_q[0], 32'h100);
    check("basic_w3", got_q[3], 32'h103);

    run_drain("wrap", 5'd30, 6'd4, 4, 0, -1);
    check("wrap_w0", got_q[0], 32'h11E);
    check("wrap_w1", got_q[1], 32'h11F);
    check("wrap_w2", got_q[2], 32'h100);
    check("wrap_w3", got_q[3], 32'h101);

    run_drain("stall", 5'd0, 6'd2, 2, 5, -1);
    run_drain("zero", 5'd3, 6'd0, 0, 0, -1);
    run_drain("clamp", 5'd5, 6'd40, 32, 0, -1);
    run_drain("inject", 5'd2, 6'd3, 3, 0, 4);

    // Asynchronous reset while a word is stalled in HOLD.
    start_address = 5'd0; drain_count = 6'd4; start_drain = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    start_drain = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (m_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("rst_hold_reached", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_read_en", 32'(read_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_valid || read_en || busy || done) seen = 1'b1;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    run_drain("after_rst", 5'd9, 6'd2, 2, 0, -1);
    check("after_rst_w0", got_q[0], 32'h109);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
